startup_sequencer: RTL

Power-up and re-initialisation controller for the HDMI output path. It qualifies PLL lock and holds a fixed settle delay. It then runs the ADV7513 configuration handshake with timeout and bounded retries, and releases the video pipeline reset. It sits between the clocking/PLL block, the I2C configuration engine and the video output logic. It also restarts configuration on hot-plug and on PLL lock loss.

---
 rtl/startup_seq_pkg.sv | 22 ++
 rtl/seq_timer.sv | 43 ++++
 rtl/startup_sequencer.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/startup_seq_pkg.sv
// ---------------------------------------------------------------------------
// startup_seq_pkg
// Shared definitions for the HDMI output startup sequencer:
//   - seq_state_t : 3-bit sequencer state encoding (also exported on the
//                   debug 'state' port, so the values are fixed)
//   - CNT_W       : width of every timing / retry counter
// ---------------------------------------------------------------------------
package startup_seq_pkg;

  localparam int CNT_W = 32;

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    DELAY     = 3'd1,
    CFG_REQ   = 3'd2,
    CFG_WAIT  = 3'd3,
    RUN       = 3'd4,
    HPD_WAIT  = 3'd5,
    FAULT     = 3'd6
  } seq_state_t;

endpackage

// File: rtl/seq_timer.sv
// ---------------------------------------------------------------------------
// seq_timer
// Saturating up-counter with synchronous clear and a compare output.
// One instance is time-shared by the lock filter, the settle delay and the
// configuration timeout; the owner is selected by the sequencer state.
// Ports:
//   clock  in   system clock, rising edge
//   reset  in   synchronous, active-low
//   clear  in   force the count back to zero (wins over enable)
//   enable in   count up by one, stopping at 'limit'
//   limit  in   compare / saturation value
//   hit    out  count equals limit
// ---------------------------------------------------------------------------
module seq_timer
  import startup_seq_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic             hit
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] count;

  // Counter register. It holds at 'limit' rather than wrapping, so a state
  // that lingers after the compare point can never see a false second hit.
  always_ff @(posedge clock) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != limit)) begin
      count <= count + ONE;
    end
  end

  assign hit = (count == limit);

endmodule

// File: rtl/startup_sequencer.sv
// ---------------------------------------------------------------------------
// startup_sequencer
// Power-up / re-initialisation controller for the HDMI output path.
// Qualifies PLL lock, waits a settle delay, runs the ADV7513 configuration
// handshake with timeout and bounded retries, then releases the video
// pipeline reset. Hot-plug and PLL lock loss restart the sequence.
// Parameters:
//   LOCK_FILTER  consecutive locked cycles before lock is accepted
//   DELAY_CYCLES settle delay after lock
//   CFG_TIMEOUT  cycles allowed per configuration attempt
//   MAX_RETRIES  extra attempts after the first failure
// Ports:
//   clock         in   system clock, rising edge
//   reset         in   synchronous, active-low
//   pll_locked    in   PLL lock (synchronised)
//   hpd           in   sink hot-plug detect (synchronised)
//   cfg_start     out  one-cycle configuration request
//   cfg_done      in   configuration succeeded pulse
//   cfg_error     in   configuration failed pulse
//   video_reset_n out  active-low video pipeline reset
//   ready         out  path configured and running
//   fault         out  retries exhausted
//   state         out  current state encoding (debug)
// ---------------------------------------------------------------------------
module startup_sequencer
  import startup_seq_pkg::*;
#(
  parameter int LOCK_FILTER  = 16,
  parameter int DELAY_CYCLES = 5_040_000,
  parameter int CFG_TIMEOUT  = 1_000_000,
  parameter int MAX_RETRIES  = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pll_locked,
  input  logic       hpd,
  output logic       cfg_start,
  input  logic       cfg_done,
  input  logic       cfg_error,
  output logic       video_reset_n,
  output logic       ready,
  output logic       fault,
  output logic [2:0] state
);

  localparam logic [CNT_W-1:0] LOCK_LIMIT    = CNT_W'(LOCK_FILTER - 1);
  localparam logic [CNT_W-1:0] DELAY_LIMIT   = CNT_W'(DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LIMIT = CNT_W'(CFG_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] RETRY_MAX     = CNT_W'(MAX_RETRIES);
  localparam logic [CNT_W-1:0] ONE           = CNT_W'(1);

  seq_state_t       cur_state;
  seq_state_t       next_state;
  logic [CNT_W-1:0] retries;
  logic [CNT_W-1:0] retries_next;
  logic             hpd_prev;

  logic             timer_clear;
  logic             timer_enable;
  logic [CNT_W-1:0] timer_limit;
  logic             timer_hit;

  seq_timer u_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (timer_clear),
    .enable (timer_enable),
    .limit  (timer_limit),
    .hit    (timer_hit)
  );

  // Next-state logic and timer control. The shared timer is cleared on every
  // state change so each owner starts from zero; in WAIT_LOCK it is also
  // cleared whenever lock drops, which restarts the filter. Lock loss is
  // applied last so it overrides anything decided above, cfg_done included.
  always_comb begin
    next_state   = cur_state;
    retries_next = retries;
    timer_enable = 1'b0;
    timer_limit  = '0;

    case (cur_state)
      WAIT_LOCK: begin
        timer_enable = pll_locked;
        timer_limit  = LOCK_LIMIT;
        if (pll_locked && timer_hit) begin
          next_state = DELAY;
        end
      end
      DELAY: begin
        timer_enable = 1'b1;
        timer_limit  = DELAY_LIMIT;
        if (timer_hit) begin
          next_state = CFG_REQ;
        end
      end
      CFG_REQ: begin
        next_state = CFG_WAIT;
      end
      CFG_WAIT: begin
        timer_enable = 1'b1;
        timer_limit  = TIMEOUT_LIMIT;
        // error beats done; done beats a timeout landing in the same cycle
        if (cfg_error || (!cfg_done && timer_hit)) begin
          if (retries < RETRY_MAX) begin
            retries_next = retries + ONE;
            next_state   = CFG_REQ;
          end else begin
            next_state = FAULT;
          end
        end else if (cfg_done) begin
          next_state = RUN;
        end
      end
      RUN: begin
        if (!hpd) begin
          next_state = HPD_WAIT;
        end
      end
      HPD_WAIT: begin
        if (hpd) begin
          retries_next = '0;
          next_state   = CFG_REQ;
        end
      end
      FAULT: begin
        if (hpd && !hpd_prev) begin
          retries_next = '0;
          next_state   = CFG_REQ;
        end
      end
      default: begin
        next_state = WAIT_LOCK;
      end
    endcase

    if ((cur_state != WAIT_LOCK) && !pll_locked) begin
      next_state   = WAIT_LOCK;
      retries_next = '0;
    end

    timer_clear = (next_state != cur_state) ||
                  ((cur_state == WAIT_LOCK) && !pll_locked);
  end

  // State, retry count and hot-plug history registers. The outputs are
  // registered from next_state so they change on the same edge as 'state'
  // and never glitch.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cur_state     <= WAIT_LOCK;
      retries       <= '0;
      hpd_prev      <= 1'b0;
      cfg_start     <= 1'b0;
      video_reset_n <= 1'b0;
      ready         <= 1'b0;
      fault         <= 1'b0;
    end else begin
      cur_state     <= next_state;
      retries       <= retries_next;
      hpd_prev      <= hpd;
      cfg_start     <= (next_state == CFG_REQ);
      video_reset_n <= (next_state == RUN) || (next_state == HPD_WAIT);
      ready         <= (next_state == RUN);
      fault         <= (next_state == FAULT);
    end
  end

  assign state = cur_state;

endmodule
